// File: rtl/mem_access_unit_if.sv
`default_nettype none
// ============================================================================
//  Module      : mem_access_unit_if
//  Description : Wishbone master/slave bundle used by mem_access_unit.
//                master modport: cyc/stb/we/adr/dat/sel out, dat_i/ack_i in.
//                slave modport : the mirror image, for memories or benches.
//  Revision    : 1.0 - initial release
// ============================================================================
interface mem_access_unit_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                    wb_cyc_o;
    logic                    wb_stb_o;
    logic                    wb_we_o;
    logic [ADDR_WIDTH-1:0]   wb_adr_o;
    logic [DATA_WIDTH-1:0]   wb_dat_o;
    logic [3:0]              wb_sel_o;
    logic [DATA_WIDTH-1:0]   wb_dat_i;
    logic                    wb_ack_i;

    modport master (
        output wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o, wb_sel_o,
        input  wb_dat_i, wb_ack_i
    );

    modport slave (
        input  wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o, wb_sel_o,
        output wb_dat_i, wb_ack_i
    );
endinterface
`default_nettype wire

// File: rtl/mem_access_unit.sv
`default_nettype none
// ============================================================================
//  Module      : mem_access_unit
//  Description : Pipeline MEM-stage load/store unit driving a single-beat
//                Wishbone master. IDLE -> BUSY -> DONE; DONE lasts one cycle
//                and produces the completion pulse.
//  Ports       : clk, reset (async, active low)
//                req_valid/we/size/unsigned/addr/wdata : request from EX/MEM
//                mem_busy    : stall request to pipeline (combinational)
//                rdata/rdata_valid : aligned, extended load result + pulse
//                misalign_err: misaligned-access pulse (trap build only)
//                wb          : Wishbone master (mem_access_unit_if.master)
//  Options     : MISALIGN_TRAP_EN - misaligned half/word requests skip the
//                bus, complete with misalign_err=1 and rdata=0. Undefined:
//                low address bits are ignored and the access proceeds.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_access_unit #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  wire                     clk,
    input  wire                     reset,
    input  wire                     req_valid,
    input  wire                     req_we,
    input  wire [1:0]               req_size,
    input  wire                     req_unsigned,
    input  wire [ADDR_WIDTH-1:0]    req_addr,
    input  wire [DATA_WIDTH-1:0]    req_wdata,
    output logic                    mem_busy,
    output logic [DATA_WIDTH-1:0]   rdata,
    output logic                    rdata_valid,
    output logic                    misalign_err,
    mem_access_unit_if.master       wb
);

    localparam logic [1:0] c_SZ_BYTE = 2'b00;
    localparam logic [1:0] c_SZ_HALF = 2'b01;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                  r_state;
    state_t                  w_next;

    logic [ADDR_WIDTH-1:0]   r_adr;
    logic [DATA_WIDTH-1:0]   r_dat;
    logic [3:0]              r_sel;
    logic                    r_we;
    logic [1:0]              r_size;
    logic                    r_unsigned;
    logic [1:0]              r_off;
    logic [DATA_WIDTH-1:0]   r_rdata;

    logic [1:0]              w_off;
    logic [3:0]              w_sel_base;
    logic [3:0]              w_sel;
    logic [DATA_WIDTH-1:0]   w_wdata;
    logic [DATA_WIDTH-1:0]   w_shifted;
    logic [DATA_WIDTH-1:0]   w_load;
    logic                    w_accept;
    logic                    w_trap;

    // Request decode. The lane offset already drops the address bits that
    // a half/word access ignores, so sel and load alignment share it.
    always_comb begin
        w_off      = 2'b00;
        w_sel_base = 4'b1111;
        w_wdata    = req_wdata;
        case (req_size)
            c_SZ_BYTE: begin
                w_off      = req_addr[1:0];
                w_sel_base = 4'b0001;
                w_wdata    = {4{req_wdata[7:0]}};
            end
            c_SZ_HALF: begin
                w_off      = {req_addr[1], 1'b0};
                w_sel_base = 4'b0011;
                w_wdata    = {2{req_wdata[15:0]}};
            end
            default: ;
        endcase
    end

    assign w_sel    = w_sel_base << w_off;
    assign w_accept = (r_state == S_IDLE) && req_valid;

`ifdef MISALIGN_TRAP_EN
    logic w_misalign;
    logic r_misalign;
    assign w_misalign = ((req_size == c_SZ_HALF) && req_addr[0]) ||
                        (req_size[1] && (req_addr[1:0] != 2'b00));
    assign w_trap       = w_misalign;
    assign misalign_err = (r_state == S_DONE) && r_misalign;
`else
    assign w_trap       = 1'b0;
    assign misalign_err = 1'b0;
`endif

    // Load alignment: bring the addressed lane down to bit 0, then extend.
    assign w_shifted = wb.wb_dat_i >> {r_off, 3'b000};

    always_comb begin
        w_load = w_shifted;
        case (r_size)
            c_SZ_BYTE: w_load = r_unsigned ? {24'b0, w_shifted[7:0]}
                                           : {{24{w_shifted[7]}}, w_shifted[7:0]};
            c_SZ_HALF: w_load = r_unsigned ? {16'b0, w_shifted[15:0]}
                                           : {{16{w_shifted[15]}}, w_shifted[15:0]};
            default:   ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next state and control outputs. mem_busy drops in DONE so the
    // pipeline advances exactly once per completed access.
    always_comb begin
        w_next      = r_state;
        mem_busy    = 1'b0;
        wb.wb_cyc_o = 1'b0;
        wb.wb_stb_o = 1'b0;
        rdata_valid = 1'b0;
        case (r_state)
            S_IDLE: begin
                mem_busy = req_valid;
                if (req_valid) begin
                    w_next = w_trap ? S_DONE : S_BUSY;
                end
            end
            S_BUSY: begin
                mem_busy    = 1'b1;
                wb.wb_cyc_o = 1'b1;
                wb.wb_stb_o = 1'b1;
                if (wb.wb_ack_i) begin
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                rdata_valid = 1'b1;
                w_next      = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Bus-side registers stay stable for the whole BUSY phase because they
    // only load on the accept cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_adr      <= '0;
            r_dat      <= '0;
            r_sel      <= 4'b0000;
            r_we       <= 1'b0;
            r_size     <= 2'b00;
            r_unsigned <= 1'b0;
            r_off      <= 2'b00;
            r_rdata    <= '0;
`ifdef MISALIGN_TRAP_EN
            r_misalign <= 1'b0;
`endif
        end else begin
            if (w_accept) begin
                r_adr      <= {req_addr[ADDR_WIDTH-1:2], 2'b00};
                r_dat      <= w_wdata;
                r_sel      <= w_sel;
                r_we       <= req_we;
                r_size     <= req_size;
                r_unsigned <= req_unsigned;
                r_off      <= w_off;
`ifdef MISALIGN_TRAP_EN
                r_misalign <= w_misalign;
                if (w_misalign) begin
                    r_rdata <= '0;
                end
`endif
            end
            if ((r_state == S_BUSY) && wb.wb_ack_i && !r_we) begin
                r_rdata <= w_load;
            end
        end
    end

    assign wb.wb_adr_o = r_adr;
    assign wb.wb_dat_o = r_dat;
    assign wb.wb_sel_o = r_sel;
    assign wb.wb_we_o  = r_we;
    assign rdata       = r_rdata;

endmodule
`default_nettype wire

// File: tb/tb_mem_access_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_access_unit
//  Description : Directed self-checking bench for mem_access_unit. The bench
//                plays the Wishbone slave; every expected value is written
//                out by hand next to the stimulus.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        mem_busy;
    logic [31:0] rdata;
    logic        rdata_valid;
    logic        misalign_err;

    int n_cmp = 0;
    int n_mis = 0;
    int n_bus = 0;
    int n_vld = 0;
    logic stb_q = 1'b0;

    mem_access_unit_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) wb ();

    mem_access_unit #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_we       (req_we),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .mem_busy     (mem_busy),
        .rdata        (rdata),
        .rdata_valid  (rdata_valid),
        .misalign_err (misalign_err),
        .wb           (wb)
    );

    always #5 clk = ~clk;

    // Counts bus cycle starts and completion pulses.
    always @(negedge clk) begin
        if (wb.wb_stb_o && !stb_q) n_bus <= n_bus + 1;
        if (rdata_valid)           n_vld <= n_vld + 1;
        stb_q <= wb.wb_stb_o;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    // One complete access: accept, 'waits' cycles without ack, ack, DONE, idle.
    task automatic do_access(input string nm, input logic we, input logic [1:0] size,
                             input logic uns, input logic [31:0] addr, input logic [31:0] wdata,
                             input logic [31:0] rdat, input int waits, input logic [3:0] e_sel,
                             input logic [31:0] e_adr, input logic [31:0] e_dat,
                             input logic [31:0] e_rdata);
        @(posedge clk); #1;
        req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
        req_addr = addr; req_wdata = wdata;
        @(negedge clk);
        chk({nm, ".busy0"}, mem_busy, 1);
        chk({nm, ".cyc0"}, wb.wb_cyc_o, 0);
        @(posedge clk); #1;
        req_valid = 1'b0;
        for (int i = 0; i <= waits; i++) begin
            if (i == waits) begin
                wb.wb_ack_i = 1'b1; wb.wb_dat_i = rdat;
            end
            @(negedge clk);
            chk({nm, ".stb"}, wb.wb_stb_o, 1);
            chk({nm, ".cyc"}, wb.wb_cyc_o, 1);
            chk({nm, ".busy"}, mem_busy, 1);
            chk({nm, ".adr"}, wb.wb_adr_o, e_adr);
            chk({nm, ".sel"}, wb.wb_sel_o, e_sel);
            chk({nm, ".dat"}, wb.wb_dat_o, e_dat);
            chk({nm, ".we"}, wb.wb_we_o, we);
            @(posedge clk); #1;
        end
        wb.wb_ack_i = 1'b0; wb.wb_dat_i = 32'h0;
        @(negedge clk);
        chk({nm, ".vld"}, rdata_valid, 1);
        chk({nm, ".rdata"}, rdata, e_rdata);
        chk({nm, ".busyDone"}, mem_busy, 0);
        chk({nm, ".stbDone"}, wb.wb_stb_o, 0);
        chk({nm, ".mis"}, misalign_err, 0);
        @(posedge clk); #1;
        @(negedge clk);
        chk({nm, ".vldOff"}, rdata_valid, 0);
        chk({nm, ".rdHold"}, rdata, e_rdata);
    endtask

    int b0, v0;

    initial begin
        reset = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00;
        req_unsigned = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
        wb.wb_ack_i = 1'b0; wb.wb_dat_i = 32'h0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst.cyc", wb.wb_cyc_o, 0);
        chk("rst.stb", wb.wb_stb_o, 0);
        chk("rst.we", wb.wb_we_o, 0);
        chk("rst.sel", wb.wb_sel_o, 0);
        chk("rst.adr", wb.wb_adr_o, 0);
        chk("rst.dat", wb.wb_dat_o, 0);
        chk("rst.rdata", rdata, 0);
        chk("rst.vld", rdata_valid, 0);
        chk("rst.mis", misalign_err, 0);
        chk("rst.busy", mem_busy, 0);
        @(posedge clk); #1;
        reset = 1'b1;

        // Functional accesses
        do_access("lbs", 0, 2'b00, 0, 32'h8000_0003, 32'h1234_5678, 32'h80FF_FFFF, 0,
                  4'b1000, 32'h8000_0000, 32'h7878_7878, 32'hFFFF_FF80);
        do_access("sh", 1, 2'b01, 0, 32'h8000_0102, 32'h0000_BEEF, 32'hDEAD_BEEF, 3,
                  4'b1100, 32'h8000_0100, 32'hBEEF_BEEF, 32'hFFFF_FF80);
        do_access("lhu", 0, 2'b01, 1, 32'h8000_0002, 32'h0, 32'h8001_0000, 0,
                  4'b1100, 32'h8000_0000, 32'h0, 32'h0000_8001);
        do_access("lhs", 0, 2'b01, 0, 32'h8000_0000, 32'h0, 32'h1234_F00D, 1,
                  4'b0011, 32'h8000_0000, 32'h0, 32'hFFFF_F00D);
        do_access("lbu", 0, 2'b00, 1, 32'h8000_0001, 32'h0, 32'h0000_A500, 0,
                  4'b0010, 32'h8000_0000, 32'h0, 32'h0000_00A5);
        do_access("lw", 0, 2'b10, 0, 32'h8000_0004, 32'h0, 32'hCAFE_BABE, 0,
                  4'b1111, 32'h8000_0004, 32'h0, 32'hCAFE_BABE);
        do_access("sb", 1, 2'b00, 0, 32'h8000_0005, 32'h0000_00C3, 32'h1111_1111, 0,
                  4'b0010, 32'h8000_0004, 32'hC3C3_C3C3, 32'hCAFE_BABE);
        do_access("lw11", 0, 2'b11, 0, 32'h8000_0008, 32'hAABB_CCDD, 32'h7654_3210, 0,
                  4'b1111, 32'h8000_0008, 32'hAABB_CCDD, 32'h7654_3210);

        // Ack outside BUSY is ignored
        @(posedge clk); #1;
        wb.wb_ack_i = 1'b1; wb.wb_dat_i = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        wb.wb_ack_i = 1'b0; wb.wb_dat_i = 32'h0;
        @(negedge clk);
        chk("stray.rdata", rdata, 32'h7654_3210);
        chk("stray.vld", rdata_valid, 0);
        chk("stray.cyc", wb.wb_cyc_o, 0);

        // Back-to-back: request held across DONE with a new address
        b0 = n_bus; v0 = n_vld;
        @(posedge clk); #1;
        req_valid = 1'b1; req_we = 1'b0; req_size = 2'b10; req_unsigned = 1'b0;
        req_addr = 32'h8000_0010;
        @(negedge clk);
        chk("b2b.busy0", mem_busy, 1);
        @(posedge clk); #1;
        wb.wb_ack_i = 1'b1; wb.wb_dat_i = 32'h1111_1111;
        @(negedge clk);
        chk("b2b.adr1", wb.wb_adr_o, 32'h8000_0010);
        @(posedge clk); #1;
        wb.wb_ack_i = 1'b0; wb.wb_dat_i = 32'h0; req_addr = 32'h8000_0020;
        @(negedge clk);
        chk("b2b.vld1", rdata_valid, 1);
        chk("b2b.rdata1", rdata, 32'h1111_1111);
        chk("b2b.busyDone", mem_busy, 0);
        chk("b2b.stbDone", wb.wb_stb_o, 0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("b2b.busy3", mem_busy, 1);
        chk("b2b.stb3", wb.wb_stb_o, 0);
        @(posedge clk); #1;
        req_valid = 1'b0; wb.wb_ack_i = 1'b1; wb.wb_dat_i = 32'h2222_2222;
        @(negedge clk);
        chk("b2b.stb4", wb.wb_stb_o, 1);
        chk("b2b.adr2", wb.wb_adr_o, 32'h8000_0020);
        @(posedge clk); #1;
        wb.wb_ack_i = 1'b0; wb.wb_dat_i = 32'h0;
        @(negedge clk);
        chk("b2b.vld2", rdata_valid, 1);
        chk("b2b.rdata2", rdata, 32'h2222_2222);
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("b2b.nbus", n_bus - b0, 2);
        chk("b2b.nvld", n_vld - v0, 2);

        // Misaligned word / half
`ifdef MISALIGN_TRAP_EN
        b0 = n_bus;
        @(posedge clk); #1;
        req_valid = 1'b1; req_we = 1'b0; req_size = 2'b10; req_addr = 32'h8000_0001;
        @(negedge clk);
        chk("trap.busy0", mem_busy, 1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(negedge clk);
        chk("trap.stb", wb.wb_stb_o, 0);
        chk("trap.mis", misalign_err, 1);
        chk("trap.vld", rdata_valid, 1);
        chk("trap.rdata", rdata, 0);
        chk("trap.busy", mem_busy, 0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("trap.misOff", misalign_err, 0);
        chk("trap.vldOff", rdata_valid, 0);
        @(posedge clk); #1;
        chk("trap.nbus", n_bus - b0, 0);
`else
        do_access("lwmis", 0, 2'b10, 0, 32'h8000_0001, 32'h0, 32'h0BAD_F00D, 0,
                  4'b1111, 32'h8000_0000, 32'h0, 32'h0BAD_F00D);
        do_access("lhmis", 0, 2'b01, 0, 32'h8000_0003, 32'h0, 32'hABCD_1234, 0,
                  4'b1100, 32'h8000_0000, 32'h0, 32'hFFFF_ABCD);
`endif

        // Reset during BUSY, then a late ack
        @(posedge clk); #1;
        req_valid = 1'b1; req_we = 1'b0; req_size = 2'b10; req_addr = 32'h8000_0030;
        @(negedge clk);
        chk("rb.busy0", mem_busy, 1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(negedge clk);
        chk("rb.stb", wb.wb_stb_o, 1);
        #1 reset = 1'b0;
        #1;
        chk("rb.cyc", wb.wb_cyc_o, 0);
        chk("rb.stbRst", wb.wb_stb_o, 0);
        chk("rb.adr", wb.wb_adr_o, 0);
        chk("rb.sel", wb.wb_sel_o, 0);
        chk("rb.busy", mem_busy, 0);
        chk("rb.rdata", rdata, 0);
        @(posedge clk); #1;
        reset = 1'b1; wb.wb_ack_i = 1'b1; wb.wb_dat_i = 32'h9999_9999;
        @(negedge clk);
        chk("rb.vldLate", rdata_valid, 0);
        chk("rb.stbLate", wb.wb_stb_o, 0);
        @(posedge clk); #1;
        wb.wb_ack_i = 1'b0; wb.wb_dat_i = 32'h0;
        @(negedge clk);
        chk("rb.vldAfter", rdata_valid, 0);
        chk("rb.rdataAfter", rdata, 0);

        // Recovery after reset
        do_access("post", 0, 2'b00, 0, 32'h8000_0042, 32'h0, 32'h0055_0000, 0,
                  4'b0100, 32'h8000_0040, 32'h0, 32'h0000_0055);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, bus address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, bus data width (only 32 supported).
REQ-003 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port req_valid  input  1  EX/MEM register holds a load/store.
REQ-006 SHALL have port req_we  input  1  1=store, 0=load.
REQ-007 SHALL have port req_size  input  2  00 byte, 01 half, 10 word, 11 treated as word.
REQ-008 SHALL have port req_unsigned  input  1  zero-extend load when 1, sign-extend when 0.
REQ-009 SHALL have ports req_addr  input  ADDR_WIDTH  byte address, and req_wdata  input  32  store data, right-aligned.
REQ-010 SHALL have port mem_busy  output  1  drives the stall controller's mem input.
REQ-011 SHALL have ports rdata  output  32  aligned, extended load data, and rdata_valid  output  1  one-cycle completion pulse.
REQ-012 SHALL have port misalign_err  output  1  one-cycle misaligned-access pulse.
REQ-013 SHALL have Wishbone master ports: wb_cyc_o, wb_stb_o, wb_we_o  output  1; wb_adr_o  output  ADDR_WIDTH; wb_dat_o  output  32; wb_sel_o  output  4; wb_dat_i  input  32; wb_ack_i  input  1.

Function
REQ-014 SHALL implement FSM states IDLE, BUSY, DONE.
REQ-015 IDLE: req_valid=1 -> latch request, go BUSY (or DONE per REQ-022); else stay.
REQ-016 BUSY: wb_cyc_o=wb_stb_o=1 with registered adr/dat/sel/we held stable; wb_ack_i=1 -> capture wb_dat_i, go DONE.
REQ-017 DONE: exactly one cycle, rdata_valid=1, req_valid ignored, then IDLE.
REQ-018 mem_busy SHALL be combinational: (IDLE and req_valid) or BUSY; low in DONE so the pipeline advances exactly once.
REQ-019 Latency: accept cycle 0, stb from cycle 1; ack in cycle N gives DONE in N+1; minimum mem_busy high 2 cycles.
REQ-020 wb_adr_o = {req_addr[ADDR_WIDTH-1:2], 2'b00}; wb_sel_o: byte 0001<<addr[1:0], half 0011<<{addr[1],0}, word 1111.
REQ-021 wb_dat_o: byte replicated x4, half replicated x2, word as-is; loads: wb_dat_i >> 8*addr[1:0], then size-wise sign/zero extension; stores leave rdata unchanged.
REQ-022 Misaligned = half with addr[0]=1, or word with addr[1:0]!=0; handling per REQ-027/028.
REQ-023 wb_ack_i outside BUSY SHALL be ignored; rdata holds last value until next completion.

Reset
REQ-024 reset low SHALL immediately force IDLE, wb_cyc_o=wb_stb_o=wb_we_o=0, wb_sel_o=0, wb_adr_o=0, wb_dat_o=0, rdata=0, rdata_valid=0, misalign_err=0.
REQ-025 Reset mid-BUSY SHALL abort the cycle without waiting for ack; a late ack after release SHALL be ignored.
REQ-026 After release, first request accepted no earlier than first clk edge with reset high.

Configuration
REQ-027 With MISALIGN_TRAP_EN defined: misaligned request issues no bus cycle, goes IDLE->DONE, misalign_err=1 in DONE, rdata forced 0, no memory written.
REQ-028 Without MISALIGN_TRAP_EN: misalign_err tied 0; half ignores addr[0], word ignores addr[1:0]; access proceeds normally.

Verification
REQ-029 Load byte signed, addr 0x8000_0003, wb_dat_i 0x80FF_FFFF, ack in cycle 1 -> wb_sel_o 1000, rdata 0xFFFF_FF80, rdata_valid cycle 2, mem_busy high cycles 0-1.
REQ-030 Store half, addr 0x8000_0102, wdata 0x0000_BEEF, ack after 3 wait cycles -> adr 0x8000_0100, sel 1100, dat 0xBEEF_BEEF, we=1, mem_busy high 5 cycles.
REQ-031 Load half unsigned, addr 0x8000_0002, wb_dat_i 0x8001_0000 -> rdata 0x0000_8001.
REQ-032 Back-to-back: req_valid held across DONE with a new address -> second cycle starts only after DONE; exactly two bus cycles, two rdata_valid pulses.
REQ-033 Reset low during BUSY -> cyc/stb 0 same cycle; ack one cycle after release -> no rdata_valid.
REQ-034 Word load at 0x8000_0001: with MISALIGN_TRAP_EN -> no stb, misalign_err pulse, rdata 0; without -> adr 0x8000_0000, sel 1111.
